// File: rtl/sd_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sd_access_arbiter_pkg
// Shared definitions for the SD access arbiter and its round-robin picker:
//   - arbStateT : one-hot FSM state encodings (IDLE, SWITCH, ISSUE, BUSY, DONE)
//   - DIR_READ / DIR_WRITE : request direction encodings (CLI_WR bit values)
//   - clog2() : constant ceiling-log2 used to size index and counter fields
// No ports (package).
// -----------------------------------------------------------------------------
package sd_access_arbiter_pkg;

   // One-hot encoding keeps every state decode a single flop bit.
   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      SWITCH = 5'b00010,
      ISSUE  = 5'b00100,
      BUSY   = 5'b01000,
      DONE   = 5'b10000
   } arbStateT;

   localparam logic DIR_READ  = 1'b0;
   localparam logic DIR_WRITE = 1'b1;

   // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(100) = 7.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/sd_access_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// sd_access_arbiter_rr_pick
// Combinational round-robin priority encoder. Returns the first asserted
// request at or after the pointer, searching upward and wrapping past the top.
// Ports:
//   i_req    [N_CLIENTS-1:0] request vector
//   i_ptr    [IDX_W-1:0]     highest-priority client index (must be < N_CLIENTS)
//   o_winner [IDX_W-1:0]     selected client index (0 when nothing requests)
//   o_valid                  at least one request is asserted
// -----------------------------------------------------------------------------
module sd_access_arbiter_rr_pick
   import sd_access_arbiter_pkg::*;
#(
   parameter int N_CLIENTS = 4,
   parameter int IDX_W     = clog2(N_CLIENTS)
)(
   input  logic [N_CLIENTS-1:0] i_req,
   input  logic [IDX_W-1:0]     i_ptr,
   output logic [IDX_W-1:0]     o_winner,
   output logic                 o_valid
);

   logic [IDX_W:0] w_sum;

   // Walk the offsets from farthest to nearest so the nearest requester to the
   // pointer overwrites any earlier hit; avoids a loop break. The wrap is a
   // conditional subtract because N_CLIENTS need not be a power of two.
   always_comb begin
      o_valid  = 1'b0;
      o_winner = '0;
      w_sum    = '0;
      for (int off = N_CLIENTS - 1; off >= 0; off--) begin
         w_sum = {1'b0, i_ptr} + (IDX_W+1)'(off);
         if (w_sum >= (IDX_W+1)'(N_CLIENTS)) begin
            w_sum = w_sum - (IDX_W+1)'(N_CLIENTS);
         end
         if (i_req[w_sum[IDX_W-1:0]]) begin
            o_valid  = 1'b1;
            o_winner = w_sum[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sd_access_arbiter.sv
// -----------------------------------------------------------------------------
// sd_access_arbiter
// Shares the single SD controller among N_CLIENTS requesters with per-client
// request/grant/done handshakes and round-robin fairness. Address, write data
// and direction are captured at grant; all outputs are registered.
// Optional build macro: SD_ARB_WATCHDOG_EN adds a TIMEOUT_CYC watchdog over
// ISSUE/BUSY that aborts the transaction and pulses o_cli_err.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cli_req/i_cli_wr      per-client request level and direction (1=write)
//   i_cli_addr/i_cli_wdata  packed per-client address / write data
//   o_cli_gnt               one-hot grant held for the whole transaction
//   o_cli_done              one-cycle completion pulse to the granted client
//   o_cli_err               one-cycle watchdog abort pulse (0 without watchdog)
//   i_sd_has_initialized    controller ready
//   i_sd_is_reading/writing controller busy flags
//   o_sd_to_read/write      controller commands
//   o_sd_address/o_sd_wdata latched address / write data for the controller
// -----------------------------------------------------------------------------
module sd_access_arbiter
   import sd_access_arbiter_pkg::*;
#(
   parameter int N_CLIENTS   = 4,
   parameter int ADDR_W      = 32,
   parameter int WDATA_W     = 16,
   parameter int TIMEOUT_CYC = 2**24
)(
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [N_CLIENTS-1:0]         i_cli_req,
   input  logic [N_CLIENTS-1:0]         i_cli_wr,
   input  logic [N_CLIENTS*ADDR_W-1:0]  i_cli_addr,
   input  logic [N_CLIENTS*WDATA_W-1:0] i_cli_wdata,
   output logic [N_CLIENTS-1:0]         o_cli_gnt,
   output logic [N_CLIENTS-1:0]         o_cli_done,
   output logic                         o_cli_err,
   input  logic                         i_sd_has_initialized,
   input  logic                         i_sd_is_reading,
   input  logic                         i_sd_is_writing,
   output logic                         o_sd_to_read,
   output logic                         o_sd_to_write,
   output logic [ADDR_W-1:0]            o_sd_address,
   output logic [WDATA_W-1:0]           o_sd_wdata
);

   localparam int IDX_W = clog2(N_CLIENTS);

   arbStateT               r_state;
   arbStateT               w_next_state;
   logic [IDX_W-1:0]       r_ptr;
   logic [IDX_W-1:0]       r_winner;
   logic [IDX_W-1:0]       w_pick_idx;
   logic                   w_pick_valid;
   logic                   r_dir;
   logic [N_CLIENTS-1:0]   r_gnt;
   logic [N_CLIENTS-1:0]   r_done;
   logic [N_CLIENTS-1:0]   w_gnt_nxt;
   logic [N_CLIENTS-1:0]   w_done_nxt;
   logic                   r_to_read;
   logic                   r_to_write;
   logic                   w_to_read_nxt;
   logic                   w_to_write_nxt;
   logic [ADDR_W-1:0]      r_addr;
   logic [WDATA_W-1:0]     r_wdata;
   logic                   w_grant_now;
   logic                   w_busy_seen;
   logic                   w_abort;

   function automatic logic [N_CLIENTS-1:0] oneHot(input logic [IDX_W-1:0] idx);
      oneHot      = '0;
      oneHot[idx] = 1'b1;
   endfunction

   sd_access_arbiter_rr_pick #(
      .N_CLIENTS (N_CLIENTS),
      .IDX_W     (IDX_W)
   ) u_rr_pick (
      .i_req    (i_cli_req),
      .i_ptr    (r_ptr),
      .o_winner (w_pick_idx),
      .o_valid  (w_pick_valid)
   );

   // A grant is only taken from IDLE once the controller reports ready; until
   // then requests simply stay pending at the clients.
   assign w_grant_now = (r_state == IDLE) && i_sd_has_initialized && w_pick_valid;

   // The command is held until the busy flag matching the latched direction
   // rises, so a stale flag of the other direction cannot release it.
   assign w_busy_seen = (r_dir == DIR_WRITE) ? i_sd_is_writing : i_sd_is_reading;

`ifdef SD_ARB_WATCHDOG_EN
   localparam int WDOG_W = clog2(TIMEOUT_CYC) + 1;

   logic [WDOG_W-1:0] r_wdog_cnt;
   logic              r_err;

   // Counts cycles spent in ISSUE and BUSY; zeroed as a new grant is taken so
   // it starts from 0 on ISSUE entry. Abort fires on the cycle that would make
   // the count reach TIMEOUT_CYC.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wdog_cnt <= '0;
      end else if (w_grant_now) begin
         r_wdog_cnt <= '0;
      end else if ((r_state == ISSUE) || (r_state == BUSY)) begin
         r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
   end

   assign w_abort = ((r_state == ISSUE) || (r_state == BUSY)) &&
                    (r_wdog_cnt == WDOG_W'(TIMEOUT_CYC - 1));

   // Error pulse lines up with the done pulse of the aborted transaction.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_abort;
      end
   end

   assign o_cli_err = r_err;
`else
   assign w_abort   = 1'b0;
   assign o_cli_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic. A watchdog abort overrides the normal ISSUE/BUSY flow
   // and returns straight to IDLE; the controller itself is never aborted.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (w_grant_now) w_next_state = SWITCH;
         SWITCH:  w_next_state = ISSUE;
         ISSUE:   if (w_busy_seen) w_next_state = BUSY;
         BUSY:    if (!i_sd_is_reading && !i_sd_is_writing) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
      if (w_abort) begin
         w_next_state = IDLE;
      end
   end

   // Output decode from the next state so every output is a plain flop.
   // Grant covers SWITCH..BUSY, drops as DONE pulses; commands only in ISSUE.
   always_comb begin
      w_gnt_nxt      = '0;
      w_done_nxt     = '0;
      w_to_read_nxt  = 1'b0;
      w_to_write_nxt = 1'b0;
      if ((w_next_state == SWITCH) || (w_next_state == ISSUE) || (w_next_state == BUSY)) begin
         w_gnt_nxt = w_grant_now ? oneHot(w_pick_idx) : oneHot(r_winner);
      end
      if ((w_next_state == DONE) || w_abort) begin
         w_done_nxt = oneHot(r_winner);
      end
      if (w_next_state == ISSUE) begin
         w_to_read_nxt  = (r_dir == DIR_READ);
         w_to_write_nxt = (r_dir == DIR_WRITE);
      end
   end

   // Output registers plus the grant-time capture of the winner's request.
   // Address and data are frozen here, so client changes after the grant
   // cannot reach the controller. The pointer moves past the winner as the
   // transaction finishes (normally or by abort).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_gnt      <= '0;
         r_done     <= '0;
         r_to_read  <= 1'b0;
         r_to_write <= 1'b0;
         r_winner   <= '0;
         r_dir      <= DIR_READ;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_ptr      <= '0;
      end else begin
         r_gnt      <= w_gnt_nxt;
         r_done     <= w_done_nxt;
         r_to_read  <= w_to_read_nxt;
         r_to_write <= w_to_write_nxt;
         if (w_grant_now) begin
            r_winner <= w_pick_idx;
            r_dir    <= i_cli_wr[w_pick_idx];
            r_addr   <= i_cli_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
            r_wdata  <= i_cli_wdata[int'(w_pick_idx)*WDATA_W +: WDATA_W];
         end
         if ((r_state == DONE) || w_abort) begin
            r_ptr <= (r_winner == IDX_W'(N_CLIENTS - 1)) ? '0 : r_winner + 1'b1;
         end
      end
   end

   assign o_cli_gnt     = r_gnt;
   assign o_cli_done    = r_done;
   assign o_sd_to_read  = r_to_read;
   assign o_sd_to_write = r_to_write;
   assign o_sd_address  = r_addr;
   assign o_sd_wdata    = r_wdata;

endmodule
